// File: rtl/jk_pkg.sv
// Shared definitions for the JK register family: operation-mode encoding.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_MODE_JK   = 2'b00,
        JK_MODE_UP   = 2'b01,
        JK_MODE_DN   = 2'b10,
        JK_MODE_HOLD = 2'b11
    } jk_mode_e;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous reset (to rst_val), preset and enable.
// q_bar is a second register loaded with the complement, never derived from q.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic en,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    // NOTE: sequential state uses non-blocking assignments so every cell samples
    // its neighbours' pre-edge values; blocking here would race across cells.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= rst_val;
            q_bar <= ~rst_val;
        end else if (set) begin
            q     <= 1'b1;
            q_bar <= 1'b0;
        end else if (en) begin
            case ({j, k})
                2'b01: begin
                    q     <= 1'b0;
                    q_bar <= 1'b1;
                end
                2'b10: begin
                    q     <= 1'b1;
                    q_bar <= 1'b0;
                end
                2'b11: begin
                    q     <= ~q;
                    q_bar <= ~q_bar;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jk_reg_n.sv
// WIDTH-bit register of JK cells with JK / up / down / hold modes and a tc flag.
// Counter modes and tc are built only when JK_REG_N_COUNT_EN is defined.
module jk_reg_n
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
);

    jk_mode_e         mode_e;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;

    assign mode_e = jk_mode_e'(mode);

`ifdef JK_REG_N_COUNT_EN
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;

    // Ripple toggle-enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic ones;
        logic zeros;
        ones  = 1'b1;
        zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = ones;
            dn_t[i] = zeros;
            ones    = ones & q[i];
            zeros   = zeros & ~q[i];
        end
    end
`endif

    // NOTE: defaults assigned first so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        j_eff = '0;
        k_eff = '0;
        case (mode_e)
            JK_MODE_JK: begin
                j_eff = j;
                k_eff = k;
            end
`ifdef JK_REG_N_COUNT_EN
            JK_MODE_UP: begin
                j_eff = up_t;
                k_eff = up_t;
            end
            JK_MODE_DN: begin
                j_eff = dn_t;
                k_eff = dn_t;
            end
`endif
            default: ;
        endcase
    end

`ifdef JK_REG_N_COUNT_EN
    assign tc = en & (((mode_e == JK_MODE_UP) & (&q)) |
                      ((mode_e == JK_MODE_DN) & ~(|q)));
`else
    assign tc = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .set     (set),
            .en      (en),
            .rst_val (RST_VAL[i]),
            .j       (j_eff[i]),
            .k       (k_eff[i]),
            .q       (q[i]),
            .q_bar   (q_bar[i])
        );
    end

endmodule

// File: tb/tb_jk_reg_n.sv
// Self-checking bench for jk_reg_n: three instances (8-bit RST_VAL 0, 8-bit RST_VAL A5,
// 1-bit) against an arithmetic reference model; honours JK_REG_N_COUNT_EN.
module tb_jk_reg_n;

    logic       clk;
    logic       rst, set, en;
    logic [1:0] mode;
    logic [7:0] j, k;
    logic [7:0] q0, qb0, q1, qb1;
    logic [0:0] q2, qb2;
    logic       tc0, tc1, tc2;

    int tests = 0;
    int fails = 0;

    jk_reg_n #(.WIDTH(8), .RST_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode),
        .j(j), .k(k), .q(q0), .q_bar(qb0), .tc(tc0));

    jk_reg_n #(.WIDTH(8), .RST_VAL(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode),
        .j(j), .k(k), .q(q1), .q_bar(qb1), .tc(tc1));

    jk_reg_n #(.WIDTH(1), .RST_VAL(1'b0)) dut2 (
        .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode),
        .j(j[0:0]), .k(k[0:0]), .q(q2), .q_bar(qb2), .tc(tc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: next value from the rules, using plain arithmetic.
    function automatic logic [7:0] nxt(input logic [7:0] cur, input int w, input logic [7:0] rv,
                                       input logic r, input logic s, input logic e,
                                       input logic [1:0] m, input logic [7:0] jj, input logic [7:0] kk);
        logic [7:0] mask;
        mask = 8'((1 << w) - 1);
        if (r) return rv & mask;
        if (s) return mask;
        if (!e) return cur;
        case (m)
            2'd0: return ((jj & ~cur) | (~kk & cur)) & mask;
`ifdef JK_REG_N_COUNT_EN
            2'd1: return (cur + 8'd1) & mask;
            2'd2: return (cur - 8'd1) & mask;
`endif
            default: return cur;
        endcase
    endfunction

    function automatic logic tc_model(input logic [7:0] cur, input int w, input logic e,
                                      input logic [1:0] m);
        logic [7:0] mask;
        mask = 8'((1 << w) - 1);
`ifdef JK_REG_N_COUNT_EN
        return e && ((m == 2'd1 && cur == mask) || (m == 2'd2 && cur == 8'd0));
`else
        return 1'b0;
`endif
    endfunction

    logic [7:0] mq [3];
    bit         valid = 1'b0;

    always @(posedge clk) begin
        if (rst) valid <= 1'b1;
        mq[0] <= nxt(mq[0], 8, 8'h00, rst, set, en, mode, j, k);
        mq[1] <= nxt(mq[1], 8, 8'hA5, rst, set, en, mode, j, k);
        mq[2] <= nxt(mq[2], 1, 8'h00, rst, set, en, mode, j, k);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            check("q0",  {24'd0, q0},  {24'd0, mq[0]});
            check("qb0", {24'd0, qb0}, {24'd0, ~mq[0]});
            check("tc0", {31'd0, tc0}, {31'd0, tc_model(mq[0], 8, en, mode)});
            check("q1",  {24'd0, q1},  {24'd0, mq[1]});
            check("qb1", {24'd0, qb1}, {24'd0, ~mq[1]});
            check("tc1", {31'd0, tc1}, {31'd0, tc_model(mq[1], 8, en, mode)});
            check("q2",  {31'd0, q2},  {31'd0, mq[2][0]});
            check("qb2", {31'd0, qb2}, {31'd0, ~mq[2][0]});
            check("tc2", {31'd0, tc2}, {31'd0, tc_model(mq[2], 1, en, mode)});
        end
    end

    task automatic step(input logic r, input logic s, input logic e, input logic [1:0] m,
                        input logic [7:0] jj, input logic [7:0] kk);
        rst  = r;
        set  = s;
        en   = e;
        mode = m;
        j    = jj;
        k    = kk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; set = 1'b0; en = 1'b0; mode = 2'd3; j = '0; k = '0;
        @(negedge clk);

        // Reset values for both RST_VAL settings.
        step(1, 0, 1, 2'd0, 8'h00, 8'h00);
        check("rst_q0",  {24'd0, q0},  32'h00);
        check("rst_qb0", {24'd0, qb0}, 32'hFF);
        check("rst_q1",  {24'd0, q1},  32'hA5);
        check("rst_qb1", {24'd0, qb1}, 32'h5A);

        // JK table: hold/set/clear/toggle per bit.
        step(0, 0, 1, 2'd0, 8'h0F, 8'hF0);
        check("jk_load", {24'd0, q0}, 32'h0F);
        step(0, 0, 1, 2'd0, 8'hF0, 8'h3C);
        check("jk_mix", {24'd0, q0}, 32'hF3);

        // en=0 holds even in JK mode with toggle inputs.
        step(0, 0, 0, 2'd0, 8'hFF, 8'hFF);
        check("en0_hold", {24'd0, q0}, 32'hF3);

`ifdef JK_REG_N_COUNT_EN
        step(0, 0, 1, 2'd0, 8'hFE, 8'h01);
        mode = 2'd1;
        #1;
        check("up_tc_fe", {31'd0, tc0}, 32'd0);
        step(0, 0, 1, 2'd1, 8'h00, 8'h00);
        check("up_ff", {24'd0, q0}, 32'hFF);
        check("up_tc_ff", {31'd0, tc0}, 32'd1);
        step(0, 0, 1, 2'd1, 8'h00, 8'h00);
        check("up_wrap", {24'd0, q0}, 32'h00);
        check("up_tc_00", {31'd0, tc0}, 32'd0);

        step(0, 0, 1, 2'd0, 8'h01, 8'hFE);
        mode = 2'd2;
        step(0, 0, 1, 2'd2, 8'h00, 8'h00);
        check("dn_00", {24'd0, q0}, 32'h00);
        check("dn_tc_00", {31'd0, tc0}, 32'd1);
        step(0, 0, 1, 2'd2, 8'h00, 8'h00);
        check("dn_wrap", {24'd0, q0}, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 2'd2, 8'h00, 8'h00);
            check("dn_en0_q", {24'd0, q0}, 32'hFF);
            check("dn_en0_tc", {31'd0, tc0}, 32'd0);
        end
`else
        step(0, 0, 1, 2'd0, 8'h10, 8'hEF);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 2'd1, 8'h00, 8'h00);
            check("nocnt_q", {24'd0, q0}, 32'h10);
            check("nocnt_tc", {31'd0, tc0}, 32'd0);
        end
`endif

        // rst wins over set during an up-count; set alone presets even with en=0.
        step(0, 0, 1, 2'd1, 8'h00, 8'h00);
        step(1, 1, 1, 2'd1, 8'h00, 8'h00);
        check("rstset_q0", {24'd0, q0}, 32'h00);
        check("rstset_q1", {24'd0, q1}, 32'hA5);
        step(0, 1, 0, 2'd1, 8'h00, 8'h00);
        check("set_q0", {24'd0, q0}, 32'hFF);
        check("set_q2", {31'd0, q2}, 32'd1);

        // Random mixed traffic.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), 8'($urandom));

        // Long count runs to cross both wrap points, with random en and mode flips.
        for (int i = 0; i < 600; i++)
            step(0, 0, $urandom_range(0, 7) != 0, (i < 300) ? 2'd1 : 2'd2,
                 8'($urandom), 8'($urandom));
        for (int i = 0; i < 300; i++)
            step(0, 0, 1, ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd2,
                 8'($urandom), 8'($urandom));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
